// File: rtl/trap_dispatch_unit.sv
// Trap dispatch: selects a committed exception or pending machine interrupt, drains the
// pipeline, strobes trap CSR values and redirects fetch. Optional macro: TRAP_MTVAL_EN.
//
// state    | meaning
// IDLE     | watching the commit head for a trap
// FLUSH    | flush requested, waiting for the pipeline to drain
// CSRWR    | one-cycle mcause/mepc/mtval write strobe
// REDIRECT | fetch redirect offered until accepted
module trap_dispatch_unit #(
  parameter int XLEN    = 64,
  parameter int CAUSE_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_commit_valid,
  input  logic               i_commit_except,
  input  logic [CAUSE_W-1:0] i_commit_cause,
  input  logic [XLEN-1:0]    i_commit_pc,
  input  logic [XLEN-1:0]    i_commit_tval,
  input  logic [15:0]        i_mip,
  input  logic [15:0]        i_mie,
  input  logic               i_mstatus_mie,
  input  logic [XLEN-1:0]    i_mtvec,
  output logic               o_commit_stall,
  output logic               o_flush_req,
  input  logic               i_flush_ack,
  output logic               o_csr_wen,
  output logic [XLEN-1:0]    o_mcause,
  output logic [XLEN-1:0]    o_mepc,
  output logic [XLEN-1:0]    o_mtval,
  output logic               o_redirect_valid,
  output logic [XLEN-1:0]    o_redirect_pc,
  input  logic               i_redirect_ready,
  output logic               o_busy
);

  typedef enum logic [1:0] {IDLE, FLUSH, CSRWR, REDIRECT} state_t;

  localparam logic [15:0] IRQ_MASK = 16'h0AAA;  // codes 1,3,5,7,9,11

  state_t             state;
  logic               stall_q;
  logic               lat_irq;
  logic [CAUSE_W-1:0] lat_code;
  logic [XLEN-1:0]    lat_epc;

  logic [15:0]        irq_pend;
  logic               irq_eligible;
  logic [CAUSE_W-1:0] irq_code;
  logic               cause_reserved;
  logic               take_irq;
  logic               take_exc;
  logic [XLEN-1:0]    vec_base;
  logic [XLEN-1:0]    vec_target;
  logic [XLEN-1:0]    mcause_val;

  assign irq_pend     = i_mip & i_mie & IRQ_MASK;
  assign irq_eligible = i_mstatus_mie & (|irq_pend);

  always_comb begin
    irq_code = '0;
    if      (irq_pend[11]) irq_code = CAUSE_W'(11);
    else if (irq_pend[3])  irq_code = CAUSE_W'(3);
    else if (irq_pend[7])  irq_code = CAUSE_W'(7);
    else if (irq_pend[9])  irq_code = CAUSE_W'(9);
    else if (irq_pend[1])  irq_code = CAUSE_W'(1);
    else if (irq_pend[5])  irq_code = CAUSE_W'(5);
  end

  assign cause_reserved = (i_commit_cause == CAUSE_W'(10)) ||
                          (i_commit_cause == CAUSE_W'(14)) ||
                          ((i_commit_cause >= CAUSE_W'(16)) && (i_commit_cause <= CAUSE_W'(23)));

  assign take_irq = (state == IDLE) && i_commit_valid && irq_eligible;
  assign take_exc = (state == IDLE) && i_commit_valid && i_commit_except && !irq_eligible;

  // The head must not commit in the very cycle the trap is latched.
  assign o_commit_stall = stall_q | take_irq | take_exc;

  assign vec_base   = {i_mtvec[XLEN-1:2], 2'b00};
  assign vec_target = ((i_mtvec[1:0] == 2'b01) && lat_irq) ?
                      vec_base + XLEN'({lat_code, 2'b00}) : vec_base;
  assign mcause_val = {lat_irq, {(XLEN-1-CAUSE_W){1'b0}}, lat_code};

  assign o_mcause = o_csr_wen ? mcause_val : '0;
  assign o_mepc   = o_csr_wen ? lat_epc    : '0;

`ifdef TRAP_MTVAL_EN
  logic [XLEN-1:0] lat_tval;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_tval <= '0;
    end else if (take_irq || (take_exc && cause_reserved)) begin
      lat_tval <= '0;
    end else if (take_exc) begin
      lat_tval <= i_commit_tval;
    end
  end

  assign o_mtval = o_csr_wen ? lat_tval : '0;
`else
  logic unused_tval;

  assign unused_tval = ^i_commit_tval;
  assign o_mtval     = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      stall_q          <= 1'b0;
      lat_irq          <= 1'b0;
      lat_code         <= '0;
      lat_epc          <= '0;
      o_flush_req      <= 1'b0;
      o_csr_wen        <= 1'b0;
      o_redirect_valid <= 1'b0;
      o_redirect_pc    <= '0;
      o_busy           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take_irq || take_exc) begin
            lat_irq     <= take_irq;
            lat_code    <= take_irq ? irq_code :
                           (cause_reserved ? CAUSE_W'(2) : i_commit_cause);
            lat_epc     <= i_commit_pc;
            stall_q     <= 1'b1;
            o_flush_req <= 1'b1;
            o_busy      <= 1'b1;
            state       <= FLUSH;
          end
        end
        FLUSH: begin
          if (i_flush_ack) begin
            o_flush_req <= 1'b0;
            o_csr_wen   <= 1'b1;
            state       <= CSRWR;
          end
        end
        CSRWR: begin
          o_csr_wen        <= 1'b0;
          o_redirect_valid <= 1'b1;
          o_redirect_pc    <= vec_target;
          state            <= REDIRECT;
        end
        REDIRECT: begin
          if (i_redirect_ready) begin
            o_redirect_valid <= 1'b0;
            o_redirect_pc    <= '0;
            stall_q          <= 1'b0;
            o_busy           <= 1'b0;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_dispatch_unit.sv
// Self-checking bench for trap_dispatch_unit: directed trap scenarios plus randomized
// traps against a priority-list reference model.
module tb_trap_dispatch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_commit_valid, i_commit_except;
  logic [5:0]  i_commit_cause;
  logic [63:0] i_commit_pc, i_commit_tval, i_mtvec;
  logic [15:0] i_mip, i_mie;
  logic        i_mstatus_mie, i_flush_ack, i_redirect_ready;
  logic        o_commit_stall, o_flush_req, o_csr_wen, o_redirect_valid, o_busy;
  logic [63:0] o_mcause, o_mepc, o_mtval, o_redirect_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  trap_dispatch_unit #(.XLEN(64), .CAUSE_W(6)) dut (
    .clk(clk), .rst(rst),
    .i_commit_valid(i_commit_valid), .i_commit_except(i_commit_except),
    .i_commit_cause(i_commit_cause), .i_commit_pc(i_commit_pc),
    .i_commit_tval(i_commit_tval), .i_mip(i_mip), .i_mie(i_mie),
    .i_mstatus_mie(i_mstatus_mie), .i_mtvec(i_mtvec),
    .o_commit_stall(o_commit_stall), .o_flush_req(o_flush_req),
    .i_flush_ack(i_flush_ack), .o_csr_wen(o_csr_wen),
    .o_mcause(o_mcause), .o_mepc(o_mepc), .o_mtval(o_mtval),
    .o_redirect_valid(o_redirect_valid), .o_redirect_pc(o_redirect_pc),
    .i_redirect_ready(i_redirect_ready), .o_busy(o_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: trap rules evaluated directly from the architectural description.
  task automatic model(input logic [15:0] mip, input logic [15:0] mie, input logic msie,
                       input logic exc, input logic [5:0] cause,
                       input logic [63:0] pc, input logic [63:0] tval, input logic [63:0] mtvec,
                       output logic take, output logic [63:0] mc, output logic [63:0] epc,
                       output logic [63:0] tv, output logic [63:0] tgt);
    int prio [6] = '{11, 3, 7, 9, 1, 5};
    int code = -1;
    int c;
    logic [63:0] base;
    for (int k = 0; k < 6; k++)
      if (code < 0 && mip[prio[k]] && mie[prio[k]]) code = prio[k];
    base = mtvec - (mtvec % 4);
    take = 1'b0; mc = 0; epc = pc; tv = 0; tgt = base;
    if (msie && code >= 0) begin
      take = 1'b1;
      mc   = 64'h8000_0000_0000_0000 + 64'(code);
      if (mtvec % 4 == 1) tgt = base + 64'(4 * code);
    end else if (exc) begin
      take = 1'b1;
      c = int'(cause);
      if (c == 10 || c == 14 || (c >= 16 && c <= 23)) begin
        mc = 2;
      end else begin
        mc = 64'(c);
        tv = tval;
      end
    end
`ifndef TRAP_MTVAL_EN
    tv = 0;
`endif
  endtask

  task automatic noise(input logic en);
    if (en) begin
      i_commit_valid  = 1'b1;
      i_commit_except = 1'b1;
      i_commit_cause  = 6'($urandom);
      i_commit_pc     = {$urandom, $urandom};
      i_mip           = 16'($urandom);
      i_mie           = 16'($urandom);
      i_mstatus_mie   = 1'b1;
    end else begin
      i_commit_valid  = 1'b0;
    end
  endtask

  task automatic do_trap(input logic [15:0] mip, input logic [15:0] mie, input logic msie,
                         input logic exc, input logic [5:0] cause,
                         input logic [63:0] pc, input logic [63:0] tval, input logic [63:0] mtvec,
                         input int ack_dly, input int rdy_dly, input logic ack_early,
                         input logic nz);
    logic take;
    logic [63:0] mc, epc, tv, tgt;
    model(mip, mie, msie, exc, cause, pc, tval, mtvec, take, mc, epc, tv, tgt);
    i_mip = mip; i_mie = mie; i_mstatus_mie = msie;
    i_commit_valid = 1'b1; i_commit_except = exc; i_commit_cause = cause;
    i_commit_pc = pc; i_commit_tval = tval; i_mtvec = mtvec;
    i_flush_ack = ack_early; i_redirect_ready = 1'b0;
    #1 chk("latch_stall", 64'(o_commit_stall), 64'(take));
    @(negedge clk);
    if (!take) begin
      chk("idle_busy", 64'(o_busy), 0);
      chk("idle_flush", 64'(o_flush_req), 0);
      chk("idle_csr_wen", 64'(o_csr_wen), 0);
      chk("idle_redir", 64'(o_redirect_valid), 0);
      chk("idle_mcause", o_mcause, 0);
      i_commit_valid = 1'b0; i_flush_ack = 1'b0;
      #1 chk("idle_stall", 64'(o_commit_stall), 0);
      return;
    end
    chk("flush_req", 64'(o_flush_req), 1);
    chk("flush_busy", 64'(o_busy), 1);
    i_flush_ack = 1'b0;
    noise(nz);
    #1 chk("flush_stall", 64'(o_commit_stall), 1);
    repeat (ack_dly) begin
      @(negedge clk);
      chk("flush_hold", 64'(o_flush_req), 1);
      chk("flush_no_wen", 64'(o_csr_wen), 0);
      noise(nz);
    end
    i_flush_ack = 1'b1;
    @(negedge clk);
    i_flush_ack = 1'b0;
    chk("csr_wen", 64'(o_csr_wen), 1);
    chk("mcause", o_mcause, mc);
    chk("mepc", o_mepc, epc);
    chk("mtval", o_mtval, tv);
    chk("csr_flush_low", 64'(o_flush_req), 0);
    chk("csr_stall", 64'(o_commit_stall), 1);
    noise(nz);
    @(negedge clk);
    chk("wen_one_cycle", 64'(o_csr_wen), 0);
    chk("redir_valid", 64'(o_redirect_valid), 1);
    chk("redir_pc", o_redirect_pc, tgt);
    repeat (rdy_dly) begin
      noise(nz);
      @(negedge clk);
      chk("redir_hold_valid", 64'(o_redirect_valid), 1);
      chk("redir_hold_pc", o_redirect_pc, tgt);
      chk("redir_hold_stall", 64'(o_commit_stall), 1);
    end
    i_redirect_ready = 1'b1;
    noise(1'b0);
    @(negedge clk);
    i_redirect_ready = 1'b0;
    chk("done_valid", 64'(o_redirect_valid), 0);
    chk("done_busy", 64'(o_busy), 0);
    chk("done_stall", 64'(o_commit_stall), 0);
  endtask

  initial begin
    rst = 1'b0;
    i_commit_valid = 0; i_commit_except = 0; i_commit_cause = 0;
    i_commit_pc = 0; i_commit_tval = 0; i_mip = 0; i_mie = 0;
    i_mstatus_mie = 0; i_mtvec = 0; i_flush_ack = 0; i_redirect_ready = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(o_busy), 0);
    chk("rst_flush", 64'(o_flush_req), 0);
    chk("rst_wen", 64'(o_csr_wen), 0);
    chk("rst_redir", 64'(o_redirect_valid), 0);
    chk("rst_redir_pc", o_redirect_pc, 0);
    chk("rst_stall", 64'(o_commit_stall), 0);
    rst = 1'b1;
    @(negedge clk);

    // loadFault exception, ack after 2 cycles, ready immediately
    do_trap(16'h0, 16'h0, 1'b1, 1'b1, 6'd5, 64'h8000_0100, 64'h1234, 64'h8000_0000,
            2, 0, 1'b0, 1'b0);
    // vectored interrupt: codes 7 and 11 pending, 11 wins
    do_trap(16'h0880, 16'h0880, 1'b1, 1'b0, 6'd0, 64'h200, 64'h0, 64'h8000_0001,
            0, 0, 1'b0, 1'b0);
    // interrupt 7 beats a same-cycle ucall
    do_trap(16'h0080, 16'h0080, 1'b1, 1'b1, 6'd8, 64'h4000, 64'hdead, 64'h1000,
            1, 0, 1'b0, 1'b0);
    // globally disabled interrupt, no exception: nothing happens
    do_trap(16'h0008, 16'h0008, 1'b0, 1'b0, 6'd0, 64'h300, 64'h0, 64'h1000,
            0, 0, 1'b0, 1'b0);
    // redirect held 5 cycles; early ack ignored; noisy inputs while busy
    do_trap(16'h0, 16'h0, 1'b0, 1'b1, 6'd2, 64'h500, 64'h77, 64'h2002,
            1, 5, 1'b1, 1'b1);
    // reserved cause becomes illegal instruction with zero tval
    do_trap(16'h0, 16'h0, 1'b0, 1'b1, 6'd18, 64'h600, 64'h99, 64'h3001,
            0, 1, 1'b0, 1'b0);
    // vectored target wraps around the address space
    do_trap(16'h0200, 16'h0200, 1'b1, 1'b0, 6'd0, 64'h700, 64'h0, 64'hFFFF_FFFF_FFFF_FFF1,
            0, 0, 1'b0, 1'b0);

    // asynchronous reset during FLUSH
    i_commit_valid = 1'b1; i_commit_except = 1'b1; i_commit_cause = 6'd4;
    i_mstatus_mie = 1'b0; i_commit_pc = 64'h800;
    @(negedge clk);
    i_commit_valid = 1'b0;
    chk("rstmid_in_flush", 64'(o_flush_req), 1);
    rst = 1'b0;
    #1;
    chk("rstmid_flush", 64'(o_flush_req), 0);
    chk("rstmid_busy", 64'(o_busy), 0);
    chk("rstmid_stall", 64'(o_commit_stall), 0);
    @(negedge clk);
    rst = 1'b1;
    i_flush_ack = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("rstmid_no_wen", 64'(o_csr_wen), 0);
      chk("rstmid_idle", 64'(o_busy), 0);
    end
    i_flush_ack = 1'b0;

    for (int n = 0; n < 60; n++) begin
      do_trap(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
              6'($urandom_range(0, 31)), {$urandom, $urandom}, {$urandom, $urandom},
              {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 3),
              1'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trap_dispatch_unit.md
Name: trap_dispatch_unit

Overview:
- Consumer side of the trap-cause encoding: turns committed exceptions (rv_trap_t::exception) and pending machine interrupts (rv_trap_t::interrupt) into a precise trap entry.
- Sits after the ROB commit stage and beside the CSR file. It selects the trap, drains the pipeline, writes mcause/mepc/mtval and mstatus, then redirects fetch to the mtvec target (direct or vectored).

Parameters:
- XLEN, 64, data/address width; matches `XDEF.
- CAUSE_W, 6, exception cause width ($clog2(64)).

Ports:
- clk  in  1  core clock
- rst  in  1  reset; asynchronous, active-low
- i_commit_valid  in  1  an instruction is at the commit head this cycle
- i_commit_except  in  1  the head instruction carries an exception
- i_commit_cause  in  CAUSE_W  exception code of the head instruction
- i_commit_pc  in  XLEN  pc of the head instruction
- i_commit_tval  in  XLEN  faulting address or instruction bits
- i_mip  in  16  pending interrupt bits (index = interrupt code)
- i_mie  in  16  interrupt enable bits
- i_mstatus_mie  in  1  global machine interrupt enable
- i_mtvec  in  XLEN  trap vector CSR
- o_commit_stall  out  1  blocks commit while a trap is in progress
- o_flush_req  out  1  pipeline flush request
- i_flush_ack  in  1  pipeline drained
- o_csr_wen  out  1  one-cycle trap CSR write strobe
- o_mcause  out  XLEN  mcause value
- o_mepc  out  XLEN  mepc value
- o_mtval  out  XLEN  mtval value
- o_redirect_valid  out  1  fetch redirect request
- o_redirect_pc  out  XLEN  redirect target
- i_redirect_ready  in  1  fetch accepted the redirect
- o_busy  out  1  FSM is not IDLE

Behaviour:
- FSM states: IDLE -> FLUSH -> CSRWR -> REDIRECT -> IDLE.
- Reset: FSM = IDLE. All outputs are 0. Latched cause, epc and tval are 0.
- Interrupt eligibility: an interrupt is eligible when (i_mip & i_mie) restricted to codes {1,3,5,7,9,11} is nonzero and i_mstatus_mie = 1.
- Interrupt priority: 11 > 3 > 7 > 9 > 1 > 5.
- IDLE, eligible interrupt and i_commit_valid:
  - Latch an interrupt trap: mcause = {1, zeros, code}, epc = i_commit_pc, tval = 0.
  - The head instruction does not commit.
  - An interrupt has priority over a same-cycle exception.
- IDLE, no eligible interrupt, i_commit_valid and i_commit_except:
  - Latch mcause = zero-extended i_commit_cause, epc = i_commit_pc, tval = i_commit_tval.
- Cause codes 10, 14 and 16..23 are reserved. An exception carrying a reserved cause is latched as instIllegal (2), with tval = 0.
- On the latch cycle, o_commit_stall is asserted combinationally. The next state is FLUSH.
- FLUSH:
  - o_flush_req = 1 and o_commit_stall = 1.
  - Both stay high until i_flush_ack is sampled high, then go to CSRWR.
  - i_flush_ack in the same cycle the FSM enters FLUSH is ignored; at least one FLUSH cycle always occurs.
- CSRWR:
  - o_csr_wen = 1 for exactly one cycle; o_mcause/o_mepc/o_mtval present the latched values.
  - The CSR file also performs MPIE <= MIE and MIE <= 0 on this strobe.
  - Next state is REDIRECT.
- REDIRECT target:
  - base = {i_mtvec[XLEN-1:2], 2'b00}.
  - If i_mtvec[1:0] = 1 and the trap is an interrupt, target = base + 4*code, modulo 2^XLEN.
  - Otherwise target = base.
  - Mode values 2 and 3 are treated as direct.
- REDIRECT handshake: o_redirect_valid is held, and o_redirect_pc is stable, until i_redirect_ready is high. Return to IDLE on that cycle.
- o_commit_stall stays 1 through REDIRECT. It drops in IDLE.
- Traps arriving outside IDLE are ignored; the stall guarantees the head does not advance.
- mip changes during FLUSH, CSRWR or REDIRECT do not alter the latched trap.
- Asynchronous reset mid-operation returns to IDLE immediately. All strobes are 0 and no partial CSR write occurs.
- o_busy = (state != IDLE).
- Minimum trap latency, latch cycle to o_redirect_valid: 3 cycles, with ack on the first FLUSH cycle.

Optional Feature:
- TRAP_MTVAL_EN
  - Defined: o_mtval = latched tval, as above.
  - Undefined: o_mtval is always 0, the i_commit_tval register is removed, and i_commit_tval is unused.

Test Plan:
- Exception loadFault (5), pc=0x8000_0100, tval=0x1234, mtvec=0x8000_0000, ack after 2 cycles, ready immediately -> o_csr_wen with mcause=5, mepc=0x8000_0100, mtval=0x1234; redirect pc=0x8000_0000.
- mip=mie=0x0880 (codes 7 and 11), mstatus_mie=1, mtvec=0x8000_0001, commit pc=0x200 -> mcause=0x8000_0000_0000_000B, mepc=0x200; redirect pc=0x8000_002C.
- Interrupt code 7 plus exception ucall (8) in the same cycle -> interrupt taken, mcause=bit63|7, mepc = the ucall's pc, mtval=0.
- mstatus_mie=0 with pending mip[3] and no exception -> stays IDLE, all outputs 0.
- i_redirect_ready held low for 5 cycles -> o_redirect_valid and o_redirect_pc stable for all 6 cycles; o_commit_stall=1 throughout.
- rst pulled low during FLUSH -> next cycle shows IDLE, o_flush_req=0, and no o_csr_wen pulse ever appears.
